snitch_ro_cache_lite: RTL and testbench
=======================================

SNITCH_RO_CACHE_LITE -- requirements
Module: snitch_ro_cache_lite

Interface
REQ-001 Parameters SHALL be: AddrWidth, 48, address bits; DataWidth, 64, response word bits (power of two, >=32); LineWidth, 256, line bits (power of two, >=DataWidth); LineCount, 8, lines per way (power of two, >=2); SetCount, 2, ways (power of two, >=1); NrAddrRules, 2, cacheable regions (>=1); CntWidth, 32, counter bits.
REQ-002 Ports SHALL be: clk_i in 1 clock; rst_i in 1 asynchronous active-high reset.
REQ-003 enable_i in 1 cache enable; flush_valid_i in 1 flush request; flush_ready_o out 1 flush done.
REQ-004 start_addr_i/end_addr_i in NrAddrRules x AddrWidth cacheable region [start, end).
REQ-005 req_addr_i in AddrWidth; req_valid_i in 1; req_ready_o out 1; read requests from core side.
REQ-006 rsp_data_o out DataWidth; rsp_error_o out 1; rsp_valid_o out 1; rsp_ready_i in 1.
REQ-007 mem_req_addr_o out AddrWidth line-aligned; mem_req_bypass_o out 1 no-allocate; mem_req_valid_o out 1; mem_req_ready_i in 1.
REQ-008 mem_rsp_data_i in LineWidth; mem_rsp_error_i in 1; mem_rsp_valid_i in 1; mem_rsp_ready_o out 1.
REQ-009 hit_cnt_o, miss_cnt_o, bypass_cnt_o out CntWidth each; cnt_clear_i in 1 synchronous counter clear.

Function
REQ-010 Address split SHALL be: offset = log2(LineWidth/8) LSBs; index = next log2(LineCount) bits; tag = remaining MSBs; word select = addr[log2(LineWidth/8)-1 : log2(DataWidth/8)].
REQ-011 Storage SHALL be flop arrays per way: valid bit, tag, LineWidth data; one round-robin replacement pointer per index.
REQ-012 FSM states SHALL be IDLE, CHECK, MISS, WAIT, RESP, FLUSH.
REQ-013 IDLE: req_ready_o = !flush_valid_i; flush_valid_i goes to FLUSH and takes priority over a simultaneous request; handshake on req_valid_i && req_ready_o registers the address and goes to CHECK.
REQ-014 CHECK: cacheable = enable_i && address in any rule; cacheable hit registers the selected word, increments hit_cnt_o, goes to RESP (rsp_valid_o 2 cycles after accept); cacheable miss increments miss_cnt_o, non-cacheable increments bypass_cnt_o; both go to MISS.
REQ-015 MISS: mem_req_valid_o=1 with line-aligned address and mem_req_bypass_o=!cacheable, held stable until mem_req_ready_i, then WAIT.
REQ-016 WAIT: mem_rsp_ready_o=1; on mem_rsp_valid_i registers selected word and error, goes to RESP; allocates only if cacheable and !mem_rsp_error_i.
REQ-017 Allocation SHALL pick the lowest invalid way at the index, else the way under the round-robin pointer; the pointer SHALL advance (modulo SetCount) only on allocation that evicts.
REQ-018 RESP: rsp_valid_o=1, rsp_data_o/rsp_error_o stable until rsp_ready_i, then IDLE; hits always report rsp_error_o=0.
REQ-019 FLUSH: all valid bits cleared in one cycle, flush_ready_o=1 for exactly that cycle, return to IDLE; round-robin pointers reset to 0.
REQ-020 Changes to enable_i or rules SHALL take effect for requests reaching CHECK; cached lines are retained when enable_i drops.
REQ-021 Counters SHALL saturate at all-ones; cnt_clear_i SHALL override a same-cycle increment (result 0).
REQ-022 One request SHALL be outstanding at a time; responses return in request order.

Reset
REQ-023 On rst_i: state IDLE, all valid bits 0, pointers 0, counters 0, rsp_valid_o/mem_req_valid_o/mem_rsp_ready_o/flush_ready_o 0, rsp_data_o/rsp_error_o 0.
REQ-024 Reset mid-refill SHALL abandon the transaction with no tracking; the memory side SHALL be reset together with this block.

Verification
REQ-025 Rule0 [0x8000_0000, 0x8001_0000), enable_i=1: read 0x8000_0008 -> mem_req 0x8000_0000 bypass=0, rsp = line word 1; then read 0x8000_0010 -> rsp_valid_o 2 cycles after accept, no mem_req, hit_cnt_o=1, miss_cnt_o=1.
REQ-026 Read 0x1000_0000 twice -> two mem_req with bypass=1, bypass_cnt_o=2, no allocation; same with 0x8000_0000 and enable_i=0.
REQ-027 Reads 0x8000_0000, 0x8000_0100, 0x8000_0200 (same index) -> way0, way1 filled, third evicts way0; re-read 0x8000_0100 hits, 0x8000_0000 misses.
REQ-028 flush_valid_i and req_valid_i together in IDLE after fills -> flush_ready_o one cycle, req_ready_o 0 that cycle; following read of 0x8000_0000 misses.
REQ-029 mem_rsp_error_i=1 on refill of 0x8000_0040 -> rsp_error_o=1, re-read misses again; rsp_ready_i low 5 cycles -> rsp_valid_o and data held stable.
REQ-030 rst_i asserted during WAIT -> all outputs at REQ-023 values next cycle, cache empty; counters at max + increment stay all-ones; cnt_clear_i with hit -> 0.

Source files
------------

// File: rtl/snitch_ro_cache_lite.sv
// snitch_ro_cache_lite: small set-associative read-only cache with flop storage.
// Serves one read at a time. A hit responds two cycles after accept. A miss or
// an uncacheable access fetches a full line from memory. A line is allocated
// only for a cacheable refill that returns without error. Hit, miss and bypass
// counters saturate at all-ones.
module snitch_ro_cache_lite #(
    parameter int unsigned AddrWidth   = 48,
    parameter int unsigned DataWidth   = 64,
    parameter int unsigned LineWidth   = 256,
    parameter int unsigned LineCount   = 8,
    parameter int unsigned SetCount    = 2,
    parameter int unsigned NrAddrRules = 2,
    parameter int unsigned CntWidth    = 32
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  enable_i,
    input  logic                                  flush_valid_i,
    output logic                                  flush_ready_o,
    input  logic [NrAddrRules-1:0][AddrWidth-1:0] start_addr_i,
    input  logic [NrAddrRules-1:0][AddrWidth-1:0] end_addr_i,
    input  logic [AddrWidth-1:0]                  req_addr_i,
    input  logic                                  req_valid_i,
    output logic                                  req_ready_o,
    output logic [DataWidth-1:0]                  rsp_data_o,
    output logic                                  rsp_error_o,
    output logic                                  rsp_valid_o,
    input  logic                                  rsp_ready_i,
    output logic [AddrWidth-1:0]                  mem_req_addr_o,
    output logic                                  mem_req_bypass_o,
    output logic                                  mem_req_valid_o,
    input  logic                                  mem_req_ready_i,
    input  logic [LineWidth-1:0]                  mem_rsp_data_i,
    input  logic                                  mem_rsp_error_i,
    input  logic                                  mem_rsp_valid_i,
    output logic                                  mem_rsp_ready_o,
    output logic [CntWidth-1:0]                   hit_cnt_o,
    output logic [CntWidth-1:0]                   miss_cnt_o,
    output logic [CntWidth-1:0]                   bypass_cnt_o,
    input  logic                                  cnt_clear_i
);

    localparam int unsigned OffW         = $clog2(LineWidth / 8);
    localparam int unsigned IdxW         = $clog2(LineCount);
    localparam int unsigned TagW         = AddrWidth - OffW - IdxW;
    localparam int unsigned WordOffW     = $clog2(DataWidth / 8);
    localparam int unsigned WordsPerLine = LineWidth / DataWidth;
    localparam int unsigned WayW         = (SetCount > 1) ? $clog2(SetCount) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MISS  = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4,
        FLUSH = 3'd5
    } state_e;

    state_e state_q, state_d;

    logic [AddrWidth-1:0]                  req_addr_q;
    logic                                  cacheable_q;
    logic [DataWidth-1:0]                  rsp_data_q;
    logic                                  rsp_error_q;
    logic [CntWidth-1:0]                   hit_cnt_q, miss_cnt_q, bypass_cnt_q;
    logic [SetCount-1:0][LineCount-1:0]    valid_q;
    logic [WayW-1:0]                       rr_q   [LineCount];
    logic [TagW-1:0]                       tag_q  [SetCount][LineCount];
    logic [LineWidth-1:0]                  data_q [SetCount][LineCount];

    logic [IdxW-1:0]      req_idx_s;
    logic [TagW-1:0]      req_tag_s;
    logic                 in_rule_s;
    logic                 cacheable_s;
    logic                 hit_s;
    logic [LineWidth-1:0] hit_line_s;
    logic [WayW-1:0]      victim_s;
    logic                 evict_s;
    logic [WayW-1:0]      rr_next_s;
    logic                 alloc_s;
    logic                 inc_hit_s, inc_miss_s, inc_byp_s;

    // Pick the DataWidth word addressed by the line offset.
    function automatic logic [DataWidth-1:0] select_word(
        input logic [LineWidth-1:0] line,
        input logic [OffW-1:0]      offset
    );
        logic [DataWidth-1:0] word;
        word = '0;
        for (int unsigned w = 0; w < WordsPerLine; w++) begin
            if (OffW'(w) == (offset >> WordOffW)) begin
                word = line[w*DataWidth +: DataWidth];
            end else begin
                word = word;
            end
        end
        return word;
    endfunction

    // Saturating increment: an all-ones counter stays all-ones.
    function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
        logic [CntWidth-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CntWidth'(1);
        end
        return r;
    endfunction

    assign req_idx_s = req_addr_q[OffW +: IdxW];
    assign req_tag_s = req_addr_q[AddrWidth-1 -: TagW];

    // Cacheability is evaluated on the registered address with live enable and rules.
    always_comb begin
        in_rule_s = 1'b0;
        for (int unsigned r = 0; r < NrAddrRules; r++) begin
            if ((req_addr_q >= start_addr_i[r]) && (req_addr_q < end_addr_i[r])) begin
                in_rule_s = 1'b1;
            end else begin
                in_rule_s = in_rule_s;
            end
        end
        cacheable_s = enable_i && in_rule_s;
    end

    // Tag lookup across all ways at the request index.
    always_comb begin
        hit_s      = 1'b0;
        hit_line_s = '0;
        for (int unsigned w = 0; w < SetCount; w++) begin
            if (valid_q[w][req_idx_s] && (tag_q[w][req_idx_s] == req_tag_s)) begin
                hit_s      = 1'b1;
                hit_line_s = data_q[w][req_idx_s];
            end else begin
                hit_s      = hit_s;
                hit_line_s = hit_line_s;
            end
        end
    end

    // Victim choice: lowest invalid way, otherwise the round-robin way.
    always_comb begin
        victim_s = rr_q[req_idx_s];
        evict_s  = 1'b1;
        for (int unsigned w = 0; w < SetCount; w++) begin
            if (evict_s && !valid_q[w][req_idx_s]) begin
                victim_s = WayW'(w);
                evict_s  = 1'b0;
            end else begin
                victim_s = victim_s;
                evict_s  = evict_s;
            end
        end
        if (rr_q[req_idx_s] == WayW'(SetCount - 1)) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = rr_q[req_idx_s] + WayW'(1);
        end
    end

    assign alloc_s    = (state_q == WAIT) && mem_rsp_valid_i && cacheable_q && !mem_rsp_error_i;
    assign inc_hit_s  = (state_q == CHECK) && cacheable_s && hit_s;
    assign inc_miss_s = (state_q == CHECK) && cacheable_s && !hit_s;
    assign inc_byp_s  = (state_q == CHECK) && !cacheable_s;

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; a flush request wins over a simultaneous read.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (flush_valid_i) begin
                    state_d = FLUSH;
                end else if (req_valid_i) begin
                    state_d = CHECK;
                end else begin
                    state_d = IDLE;
                end
            end
            CHECK: begin
                if (cacheable_s && hit_s) begin
                    state_d = RESP;
                end else begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (mem_req_ready_i) begin
                    state_d = WAIT;
                end else begin
                    state_d = MISS;
                end
            end
            WAIT: begin
                if (mem_rsp_valid_i) begin
                    state_d = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = RESP;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the state register and registered datapath.
    always_comb begin
        req_ready_o      = 1'b0;
        mem_req_valid_o  = 1'b0;
        mem_req_bypass_o = 1'b0;
        mem_rsp_ready_o  = 1'b0;
        rsp_valid_o      = 1'b0;
        flush_ready_o    = 1'b0;
        case (state_q)
            IDLE:  req_ready_o = !flush_valid_i;
            MISS: begin
                mem_req_valid_o  = 1'b1;
                mem_req_bypass_o = !cacheable_q;
            end
            WAIT:  mem_rsp_ready_o = 1'b1;
            RESP:  rsp_valid_o     = 1'b1;
            FLUSH: flush_ready_o   = 1'b1;
            default: begin
                req_ready_o = 1'b0;
            end
        endcase
    end

    assign mem_req_addr_o = {req_addr_q[AddrWidth-1:OffW], {OffW{1'b0}}};
    assign rsp_data_o     = rsp_data_q;
    assign rsp_error_o    = rsp_error_q;
    assign hit_cnt_o      = hit_cnt_q;
    assign miss_cnt_o     = miss_cnt_q;
    assign bypass_cnt_o   = bypass_cnt_q;

    // Request address capture, cacheability latch and response word register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_addr_q  <= '0;
            cacheable_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_error_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        req_addr_q <= req_addr_i;
                    end
                end
                CHECK: begin
                    cacheable_q <= cacheable_s;
                    if (cacheable_s && hit_s) begin
                        rsp_data_q  <= select_word(hit_line_s, req_addr_q[OffW-1:0]);
                        rsp_error_q <= 1'b0;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid_i) begin
                        rsp_data_q  <= select_word(mem_rsp_data_i, req_addr_q[OffW-1:0]);
                        rsp_error_q <= mem_rsp_error_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Statistics counters; a clear beats any increment in the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            bypass_cnt_q <= '0;
        end else if (cnt_clear_i) begin
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
            bypass_cnt_q <= '0;
        end else begin
            if (inc_hit_s)  hit_cnt_q    <= sat_inc(hit_cnt_q);
            if (inc_miss_s) miss_cnt_q   <= sat_inc(miss_cnt_q);
            if (inc_byp_s)  bypass_cnt_q <= sat_inc(bypass_cnt_q);
        end
    end

    // Valid bits and replacement pointers; flush wipes both in one cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LineCount; i++) begin
                rr_q[i] <= '0;
            end
        end else if (state_q == FLUSH) begin
            valid_q <= '0;
            for (int unsigned i = 0; i < LineCount; i++) begin
                rr_q[i] <= '0;
            end
        end else if (alloc_s) begin
            valid_q[victim_s][req_idx_s] <= 1'b1;
            if (evict_s) begin
                rr_q[req_idx_s] <= rr_next_s;
            end
        end
    end

    // Tag and line storage; contents are meaningful only under a set valid bit.
    always_ff @(posedge clk_i) begin
        if (alloc_s) begin
            tag_q[victim_s][req_idx_s]  <= req_tag_s;
            data_q[victim_s][req_idx_s] <= mem_rsp_data_i;
        end
    end

endmodule

// File: tb/tb_snitch_ro_cache_lite.sv
// Directed bench for snitch_ro_cache_lite: table of single reads with expected
// memory traffic, data and counters, plus sequences for flush, response
// back-pressure, counter saturation/clear and reset during a refill.
module tb_snitch_ro_cache_lite;

    localparam int AW = 48;
    localparam int DW = 64;
    localparam int LW = 256;
    localparam int CW = 4;

    logic                clk_i = 1'b0;
    logic                rst_i;
    logic                enable_i;
    logic                flush_valid_i;
    logic                flush_ready_o;
    logic [1:0][AW-1:0]  start_addr_i;
    logic [1:0][AW-1:0]  end_addr_i;
    logic [AW-1:0]       req_addr_i;
    logic                req_valid_i;
    logic                req_ready_o;
    logic [DW-1:0]       rsp_data_o;
    logic                rsp_error_o;
    logic                rsp_valid_o;
    logic                rsp_ready_i;
    logic [AW-1:0]       mem_req_addr_o;
    logic                mem_req_bypass_o;
    logic                mem_req_valid_o;
    logic                mem_req_ready_i;
    logic [LW-1:0]       mem_rsp_data_i;
    logic                mem_rsp_error_i;
    logic                mem_rsp_valid_i;
    logic                mem_rsp_ready_o;
    logic [CW-1:0]       hit_cnt_o, miss_cnt_o, bypass_cnt_o;
    logic                cnt_clear_i;

    int n_checks = 0;
    int n_fail   = 0;

    snitch_ro_cache_lite #(
        .AddrWidth(AW), .DataWidth(DW), .LineWidth(LW), .LineCount(8),
        .SetCount(2), .NrAddrRules(2), .CntWidth(CW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i),
        .flush_valid_i(flush_valid_i), .flush_ready_o(flush_ready_o),
        .start_addr_i(start_addr_i), .end_addr_i(end_addr_i),
        .req_addr_i(req_addr_i), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .mem_req_addr_o(mem_req_addr_o), .mem_req_bypass_o(mem_req_bypass_o),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_rsp_data_i(mem_rsp_data_i), .mem_rsp_error_i(mem_rsp_error_i),
        .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_ready_o(mem_rsp_ready_o),
        .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o), .bypass_cnt_o(bypass_cnt_o),
        .cnt_clear_i(cnt_clear_i)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: timed out", name);
    endtask

    // Backing memory contents: each word encodes its line address and word index.
    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] addr);
        logic [AW-1:0] line_a;
        logic [1:0]    w;
        line_a = addr & ~48'h1F;
        w      = addr[4:3];
        return {line_a[39:0], 8'hA5, 6'h00, w, 8'h3C};
    endfunction

    function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] line_a);
        logic [LW-1:0] l;
        for (int w = 0; w < 4; w++) begin
            l[w*64 +: 64] = mem_word(line_a | (AW'(w) << 3));
        end
        return l;
    endfunction

    // One read: handshake, serve memory (request held 2 cycles before ready),
    // optionally assert cnt_clear in the lookup cycle and stall the response.
    task automatic do_read(
        input  logic [AW-1:0] a,
        input  logic          merr,
        input  int            hold,
        input  bit            clr,
        output bit            saw_mreq,
        output logic [AW-1:0] maddr,
        output logic          mbyp,
        output logic [DW-1:0] d,
        output logic          e,
        output int            lat,
        output bit            stable
    );
        int mcyc;
        saw_mreq = 1'b0; maddr = '0; mbyp = 1'b0; d = '0; e = 1'b0;
        lat = 0; stable = 1'b1; mcyc = 0;
        req_addr_i  = a;
        req_valid_i = 1'b1;
        rsp_ready_i = (hold == 0);
        while (!req_ready_o && lat < 50) begin
            @(negedge clk_i);
            lat++;
        end
        if (lat >= 50) timeout_fail("req_ready");
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 100) begin
            cnt_clear_i = (lat == 1) ? clr : 1'b0;
            if (mem_req_valid_o) begin
                if (!saw_mreq) begin
                    saw_mreq = 1'b1;
                    maddr    = mem_req_addr_o;
                    mbyp     = mem_req_bypass_o;
                end else if (mem_req_addr_o !== maddr || mem_req_bypass_o !== mbyp) begin
                    stable = 1'b0;
                end
                mcyc++;
                mem_req_ready_i = (mcyc >= 2);
            end else begin
                mem_req_ready_i = 1'b0;
            end
            if (mem_rsp_ready_o) begin
                mem_rsp_valid_i = 1'b1;
                mem_rsp_data_i  = mem_line(maddr);
                mem_rsp_error_i = merr;
            end else begin
                mem_rsp_valid_i = 1'b0;
                mem_rsp_error_i = 1'b0;
            end
            @(negedge clk_i);
            lat++;
        end
        cnt_clear_i     = 1'b0;
        mem_req_ready_i = 1'b0;
        mem_rsp_valid_i = 1'b0;
        mem_rsp_error_i = 1'b0;
        if (lat >= 100) timeout_fail("rsp_valid");
        d = rsp_data_o;
        e = rsp_error_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_i);
            if (!rsp_valid_o || rsp_data_o !== d || rsp_error_o !== e) stable = 1'b0;
        end
        rsp_ready_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic chk_cnt(input string tag, input int h, input int m, input int b);
        chk({tag, " hit_cnt"},    64'(hit_cnt_o),    64'(h));
        chk({tag, " miss_cnt"},   64'(miss_cnt_o),   64'(m));
        chk({tag, " bypass_cnt"}, 64'(bypass_cnt_o), 64'(b));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic          en;
        logic          merr;
        logic          exp_mreq;
        logic          exp_byp;
        logic          exp_err;
        int            exp_h;
        int            exp_m;
        int            exp_b;
    } vec_t;

    vec_t vec [21];

    initial begin
        bit            saw, st;
        logic [AW-1:0] ma;
        logic          mb, e;
        logic [DW-1:0] d;
        int            lat;
        int            cyc;

        // addr, en, merr, mem_req, bypass, err, hits, misses, bypasses (cumulative)
        vec[0]  = '{48'h0000_8000_0008, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0, 1, 0};
        vec[1]  = '{48'h0000_8000_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 1, 0};
        vec[2]  = '{48'h0000_1000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 1};
        vec[3]  = '{48'h0000_1000_0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 2};
        vec[4]  = '{48'h0000_8000_0018, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 3};
        vec[5]  = '{48'h0000_8000_0018, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, 1, 4};
        vec[6]  = '{48'h0000_8000_0018, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2, 1, 4};
        vec[7]  = '{48'h0000_9000_0020, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 2, 4};
        vec[8]  = '{48'h0000_9000_0028, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 2, 4};
        vec[9]  = '{48'h0000_9000_1000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2, 5};
        vec[10] = '{48'h0000_7FFF_FFF8, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2, 6};
        vec[11] = '{48'h0000_8000_0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3, 6};
        vec[12] = '{48'h0000_8000_0200, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3, 4, 6};
        vec[13] = '{48'h0000_8000_0108, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4, 4, 6};
        vec[14] = '{48'h0000_8000_0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4, 5, 6};
        vec[15] = '{48'h0000_8000_0200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5, 5, 6};
        vec[16] = '{48'h0000_8000_0100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 5, 6, 6};
        vec[17] = '{48'h0000_8000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6, 6, 6};
        vec[18] = '{48'h0000_8000_0040, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6, 7, 6};
        vec[19] = '{48'h0000_8000_0040, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 6, 8, 6};
        vec[20] = '{48'h0000_8000_0058, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 7, 8, 6};

        rst_i = 1'b1; enable_i = 1'b1; flush_valid_i = 1'b0;
        start_addr_i[0] = 48'h0000_8000_0000; end_addr_i[0] = 48'h0000_8001_0000;
        start_addr_i[1] = 48'h0000_9000_0000; end_addr_i[1] = 48'h0000_9000_1000;
        req_addr_i = '0; req_valid_i = 1'b0; rsp_ready_i = 1'b1;
        mem_req_ready_i = 1'b0; mem_rsp_data_i = '0; mem_rsp_error_i = 1'b0;
        mem_rsp_valid_i = 1'b0; cnt_clear_i = 1'b0;

        repeat (3) @(negedge clk_i);
        chk("reset rsp_valid",     64'(rsp_valid_o),     64'd0);
        chk("reset mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("reset mem_rsp_ready", 64'(mem_rsp_ready_o), 64'd0);
        chk("reset flush_ready",   64'(flush_ready_o),   64'd0);
        chk("reset rsp_data",      64'(rsp_data_o),      64'd0);
        chk("reset rsp_error",     64'(rsp_error_o),     64'd0);
        chk_cnt("reset", 0, 0, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        chk("idle req_ready", 64'(req_ready_o), 64'd1);

        for (int i = 0; i < 21; i++) begin
            enable_i = vec[i].en;
            do_read(vec[i].addr, vec[i].merr, 0, 1'b0, saw, ma, mb, d, e, lat, st);
            chk($sformatf("v%0d mem_req seen", i), 64'(saw), 64'(vec[i].exp_mreq));
            if (vec[i].exp_mreq) begin
                chk($sformatf("v%0d mem_req_addr", i), 64'(ma), 64'(vec[i].addr & ~48'h1F));
                chk($sformatf("v%0d bypass", i), 64'(mb), 64'(vec[i].exp_byp));
                chk($sformatf("v%0d mem_req stable", i), 64'(st), 64'd1);
            end else begin
                chk($sformatf("v%0d hit latency", i), 64'(lat), 64'd2);
            end
            chk($sformatf("v%0d rsp_data", i), d, mem_word(vec[i].addr));
            chk($sformatf("v%0d rsp_error", i), 64'(e), 64'(vec[i].exp_err));
            chk_cnt($sformatf("v%0d", i), vec[i].exp_h, vec[i].exp_m, vec[i].exp_b);
        end
        enable_i = 1'b1;

        // Response back-pressure on a hit: data and valid held for 5 cycles.
        do_read(48'h0000_8000_0048, 1'b0, 5, 1'b0, saw, ma, mb, d, e, lat, st);
        chk("hold mem_req seen", 64'(saw), 64'd0);
        chk("hold stable", 64'(st), 64'd1);
        chk("hold rsp_data", d, mem_word(48'h0000_8000_0048));
        chk("hold rsp_error", 64'(e), 64'd0);
        chk_cnt("hold", 8, 8, 6);

        // Flush and read arriving together: flush wins, read follows.
        flush_valid_i = 1'b1;
        req_addr_i    = 48'h0000_8000_0000;
        req_valid_i   = 1'b1;
        #1;
        chk("flush req_ready same cycle", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        flush_valid_i = 1'b0;
        #1;
        chk("flush_ready asserted", 64'(flush_ready_o), 64'd1);
        chk("flush req_ready in flush", 64'(req_ready_o), 64'd0);
        @(negedge clk_i);
        chk("flush_ready one cycle", 64'(flush_ready_o), 64'd0);
        do_read(48'h0000_8000_0000, 1'b0, 0, 1'b0, saw, ma, mb, d, e, lat, st);
        chk("post-flush miss", 64'(saw), 64'd1);
        chk("post-flush rsp_data", d, mem_word(48'h0000_8000_0000));
        chk_cnt("post-flush", 8, 9, 6);

        // Bypass counter saturates: 6 + 12 clamps at 15.
        for (int i = 0; i < 12; i++) begin
            do_read(48'h0000_2000_0000, 1'b0, 0, 1'b0, saw, ma, mb, d, e, lat, st);
        end
        chk_cnt("saturate", 8, 9, 15);

        // Clear during the lookup cycle of a hit wins over the increment.
        do_read(48'h0000_8000_0000, 1'b0, 0, 1'b1, saw, ma, mb, d, e, lat, st);
        chk("clear-hit mem_req seen", 64'(saw), 64'd0);
        chk_cnt("clear", 0, 0, 0);
        do_read(48'h0000_8000_0008, 1'b0, 0, 1'b0, saw, ma, mb, d, e, lat, st);
        chk("after-clear rsp_data", d, mem_word(48'h0000_8000_0008));
        chk_cnt("after-clear", 1, 0, 0);

        // Reset while waiting for refill data.
        req_addr_i  = 48'h0000_8000_0300;
        req_valid_i = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        cyc = 0;
        while (!mem_rsp_ready_o && cyc < 20) begin
            mem_req_ready_i = mem_req_valid_o;
            @(negedge clk_i);
            cyc++;
        end
        mem_req_ready_i = 1'b0;
        if (cyc >= 20) timeout_fail("reach WAIT");
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("rst-wait rsp_valid",     64'(rsp_valid_o),     64'd0);
        chk("rst-wait mem_req_valid", 64'(mem_req_valid_o), 64'd0);
        chk("rst-wait mem_rsp_ready", 64'(mem_rsp_ready_o), 64'd0);
        chk("rst-wait flush_ready",   64'(flush_ready_o),   64'd0);
        chk("rst-wait rsp_data",      64'(rsp_data_o),      64'd0);
        chk("rst-wait rsp_error",     64'(rsp_error_o),     64'd0);
        chk("rst-wait idle",          64'(req_ready_o),     64'd1);
        chk_cnt("rst-wait", 0, 0, 0);
        rst_i = 1'b0;
        @(negedge clk_i);
        do_read(48'h0000_8000_0000, 1'b0, 0, 1'b0, saw, ma, mb, d, e, lat, st);
        chk("post-reset miss", 64'(saw), 64'd1);
        chk("post-reset rsp_data", d, mem_word(48'h0000_8000_0000));
        chk_cnt("post-reset", 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
